// File: rtl/mem_access_pkg.sv
// Shared types and constants for the segmented memory access unit.
package mem_access_pkg;

    localparam int PA_W            = 20;
    localparam int SEG_SHIFT       = 4;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts REQ cycles without an acknowledge and flags the last allowed cycle.
module mem_timeout_counter
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic r,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (r || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_terminal = (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_access_unit.sv
// Segmented memory access unit: forms the physical address, runs one RAM
// handshake with a timeout and returns read data onto the shared bus.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            r,
    input  logic            req,
    input  logic            we,
    input  logic [15:0]     mo,
    input  logic [15:0]     so,
    input  logic            moe,
    inout  wire  [15:0]     bus,
    output logic [PA_W-1:0] ram_addr,
    output logic [15:0]     ram_wdata,
    input  logic [15:0]     ram_rdata,
    output logic            ram_req,
    output logic            ram_we,
    input  logic            ram_ack,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_t          r_state;
    state_t          w_nextState;
    logic [PA_W-1:0] r_addr;
    logic [15:0]     r_wdata;
    logic [15:0]     r_data;
    logic            r_we;
    logic            r_err;
    logic [PA_W-1:0] w_physAddr;
    logic            w_accept;
    logic            w_ackTaken;
    logic            w_terminal;
    logic            w_timeout;

    // Segment is shifted left by four; the carry out of the top bit is lost.
    assign w_physAddr = (PA_W'(so) << SEG_SHIFT) + PA_W'(mo);

    assign w_accept   = (r_state == IDLE) && req;
    assign w_ackTaken = (r_state == REQ) && ram_ack;
    assign w_timeout  = (r_state == REQ) && !ram_ack && w_terminal;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .r          (r),
        .i_clear    (r_state != REQ),
        .i_enable   ((r_state == REQ) && !ram_ack),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (req) w_nextState = REQ;
            REQ:     if (ram_ack || w_terminal) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // An acknowledge in the terminal cycle takes priority, so err stays clear.
    always_ff @(posedge clk) begin
        if (r) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= w_physAddr;
                r_we   <= we;
                r_err  <= 1'b0;
                if (we) begin
                    r_wdata <= bus;
                end
            end
            if (w_ackTaken && !r_we) begin
                r_data <= ram_rdata;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus       = (moe && (r_state == IDLE)) ? r_data : 16'bz;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_we    = r_we;
    assign ram_req   = (r_state == REQ);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected accesses,
// a negedge monitor checks every RAM request and completion pulse.
module tb_mem_access_unit;

    localparam int TIMEOUT = 15;

    typedef struct {
        logic [19:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic        err;
        int          reqLen;
    } exp_t;

    logic        clk = 1'b0;
    logic        r;
    logic        req;
    logic        we;
    logic [15:0] mo;
    logic [15:0] so;
    logic        moe;
    wire  [15:0] bus;
    logic [19:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_req;
    logic        ram_we;
    logic        ram_ack;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] busDrv;
    logic        busDrvEn;

    exp_t        sbQ[$];
    exp_t        monItem;
    int          monReqLen = 0;
    logic [15:0] modelData;
    int          testsRun = 0;
    int          testsFailed = 0;

    assign bus = busDrvEn ? busDrv : 16'bz;

    always #5 clk = ~clk;

    mem_access_unit #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .r         (r),
        .req       (req),
        .we        (we),
        .mo        (mo),
        .so        (so),
        .moe       (moe),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_ack   (ram_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    function automatic logic [19:0] physAddr(input logic [15:0] s, input logic [15:0] m);
        longint sum;
        sum = longint'(s) * 16 + longint'(m);
        return 20'(sum % 1048576);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every REQ cycle must match the oldest outstanding access.
    always @(negedge clk) begin
        if (ram_req === 1'b1) begin
            monReqLen++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected ram_req", 32'(ram_req), 32'd0);
            end else begin
                checkOutput("req addr", 32'(ram_addr), 32'(sbQ[0].addr));
                checkOutput("req we", 32'(ram_we), 32'(sbQ[0].we));
                checkOutput("req busy", 32'(busy), 32'd1);
                if (sbQ[0].we) begin
                    checkOutput("req wdata", 32'(ram_wdata), 32'(sbQ[0].wdata));
                end
            end
        end
        if (done === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected done", 32'(done), 32'd0);
            end else begin
                monItem = sbQ.pop_front();
                checkOutput("done err", 32'(err), 32'(monItem.err));
                checkOutput("req length", 32'(monReqLen), 32'(monItem.reqLen));
                checkOutput("done ram_req", 32'(ram_req), 32'd0);
                checkOutput("done busy", 32'(busy), 32'd1);
                checkOutput("done addr", 32'(ram_addr), 32'(monItem.addr));
            end
            monReqLen = 0;
        end else if (busy !== 1'b1) begin
            monReqLen = 0;
        end
        if (moe === 1'b1 && busy === 1'b0 && busDrvEn === 1'b0) begin
            checkOutput("bus read data", 32'(bus), 32'(modelData));
        end
    end

    // One complete access; ackAt outside 1..TIMEOUT means the RAM never answers.
    task automatic applyStimulus(input logic [15:0] soV, input logic [15:0] moV, input logic weV,
                                 input logic [15:0] wd, input int ackAt, input logic [15:0] rd,
                                 input logic [19:0] expAddr, input logic holdReq);
        exp_t e;
        bit   acked;
        acked    = (ackAt >= 1) && (ackAt <= TIMEOUT);
        e.addr   = expAddr;
        e.we     = weV;
        e.wdata  = wd;
        e.err    = !acked;
        e.reqLen = acked ? ackAt : TIMEOUT;
        sbQ.push_back(e);
        so = soV; mo = moV; we = weV; moe = 1'b0;
        busDrvEn = 1'b1; busDrv = wd; req = 1'b1; ram_ack = 1'b0;
        @(posedge clk); #1;
        checkOutput("busy after accept", 32'(busy), 32'd1);
        checkOutput("err cleared on accept", 32'(err), 32'd0);
        req = holdReq;
        so = 16'($urandom); mo = 16'($urandom); we = 1'($urandom); busDrv = 16'($urandom);
        for (int c = 1; c <= TIMEOUT; c++) begin
            ram_ack   = (c == ackAt);
            ram_rdata = (c == ackAt) ? rd : 16'($urandom);
            @(posedge clk); #1;
            if (c == ackAt) break;
        end
        ram_ack = 1'b0;
        if (acked && !weV) modelData = rd;
        @(posedge clk); #1;
        req = 1'b0;
        checkOutput("idle busy", 32'(busy), 32'd0);
        checkOutput("idle done", 32'(done), 32'd0);
        checkOutput("err hold", 32'(err), 32'(e.err));
    endtask

    // Read the data register over the bus, then confirm the unit releases it.
    task automatic idleCycle();
        logic [15:0] v;
        busDrvEn = 1'b0; moe = 1'b1; ram_ack = 1'($urandom);
        @(posedge clk); #1;
        moe = 1'b0; ram_ack = 1'b0;
        v = 16'($urandom);
        busDrvEn = 1'b1; busDrv = v;
        #1;
        checkOutput("bus released", 32'(bus), 32'(v));
    endtask

    task automatic abortAccess();
        exp_t e;
        e.addr = 20'h12350; e.we = 1'b0; e.wdata = '0; e.err = 1'b0; e.reqLen = 0;
        sbQ.push_back(e);
        so = 16'h1234; mo = 16'h0010; we = 1'b0; busDrvEn = 1'b1; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        r = 1'b1;
        @(posedge clk); #1;
        r = 1'b0;
        void'(sbQ.pop_front());
        modelData = 16'h0000;
        checkOutput("abort ram_req", 32'(ram_req), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort addr", 32'(ram_addr), 32'd0);
        ram_ack = 1'b1; ram_rdata = 16'h7777;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("late ack ignored", 32'(busy), 32'd0);
        end
        ram_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] soV, moV, wdV, rdV;
        int          pick, ackAt;
        r = 1'b1; req = 1'b0; we = 1'b0; mo = '0; so = '0; moe = 1'b1;
        ram_rdata = '0; ram_ack = 1'b0; busDrv = '0; busDrvEn = 1'b0;
        modelData = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ram_req", 32'(ram_req), 32'd0);
        checkOutput("reset ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset ram_wdata", 32'(ram_wdata), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset bus data", 32'(bus), 32'd0);
        r = 1'b0;
        idleCycle();

        applyStimulus(16'h1234, 16'h0010, 1'b0, 16'h0000, 3, 16'hBEEF, 20'h12350, 1'b0);
        idleCycle();
        applyStimulus(16'hFFFF, 16'h0010, 1'b1, 16'hA5A5, 2, 16'h1111, 20'h00000, 1'b0);
        idleCycle();
        applyStimulus(16'h0100, 16'h0001, 1'b0, 16'h0000, TIMEOUT + 5, 16'h2222, 20'h01001, 1'b0);
        idleCycle();
        applyStimulus(16'h0200, 16'h0003, 1'b0, 16'h0000, TIMEOUT, 16'h1357, 20'h02003, 1'b1);
        idleCycle();
        abortAccess();
        idleCycle();

        for (int i = 0; i < 40; i++) begin
            soV = 16'($urandom); moV = 16'($urandom);
            wdV = 16'($urandom); rdV = 16'($urandom);
            pick = $urandom_range(0, 9);
            if (pick == 0) ackAt = TIMEOUT;
            else if (pick == 1) ackAt = TIMEOUT + 1;
            else ackAt = $urandom_range(1, TIMEOUT);
            applyStimulus(soV, moV, 1'($urandom), wdV, ackAt, rdV, physAddr(soV, moV),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idleCycle();
        end
        idleCycle();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
